pc_predict_unit: RTL and testbench
==================================

// Module: pc_predict_unit
// PURPOSE
//  Parametrised next-PC generator that replaces the combinational snpc/dnpc mux in the CPU top.
//  Holds the fetch PC and supplies it to IFU over a valid/ready handshake.
//  Predicts taken control flow with a direct-mapped BTB that uses 2-bit saturating counters.
//  Accepts redirects (branch/jump/mret/ecall resolution) from the execute side.
//  Trains the BTB from resolved control-flow updates.
// PARAMETERS
//  XLEN       32            datapath / PC width
//  BTB_DEPTH  16            BTB entries; power of 2, >=2; IDX_W = $clog2(BTB_DEPTH)
//  RESET_PC   32'h8000_0000 PC loaded on reset
// PORTS
//  clk            in   1         clock
//  rst_n          in   1         async reset, active-low
//  pc_o           out  XLEN      current fetch PC
//  pc_valid_o     out  1         pc_o is valid for fetch
//  ready_i        in   1         IFU accepts pc_o this cycle
//  pred_taken_o   out  1         BTB predicts pc_o is a taken control transfer
//  pred_target_o  out  XLEN      predicted target; 0 when pred_taken_o=0
//  redirect_i     in   1         mispredict/trap; force PC
//  redirect_pc_i  in   XLEN      redirect target
//  upd_valid_i    in   1         resolved control-flow instruction
//  upd_pc_i       in   XLEN      its PC
//  upd_target_i   in   XLEN      its resolved target
//  upd_taken_i    in   1         its resolved direction
// BEHAVIOUR
//  - Reset (async assert, sync release) drives pc_o=RESET_PC, pc_valid_o=0, all BTB valid bits=0, counters=0.
//  - Reset mid-operation aborts everything, including pending updates.
//  - pc_valid_o rises 1 cycle after rst_n release and stays 1 until the next reset.
//  - Next-PC priority: redirect_i > (pc_valid_o&&ready_i&&hit&&ctr[1] -> BTB target) > (pc_valid_o&&ready_i -> pc_o+4) > hold.
//  - Redirect is taken in the cycle after redirect_i, independent of ready_i. The PC presented during the redirect cycle is dropped.
//  - pc_o+4 wraps modulo 2^XLEN. No alignment check; bits[1:0] pass through.
//  - Lookup is combinational on pc_o. idx=pc_o[IDX_W+1:2], tag=pc_o[XLEN-1:IDX_W+2].
//  - hit = valid[idx] && tag match. pred_taken_o = hit && ctr[idx][1].
//  - Update is registered; BTB state changes at the clock edge after upd_valid_i.
//    - Tag hit: ctr increments if upd_taken_i, decrements otherwise, saturating at 0 and 3. Target is rewritten when taken.
//    - Tag miss and taken: allocate/replace the entry with valid=1, tag, target, ctr=2 (weak taken).
//    - Tag miss and not taken: no change.
//  - Update and lookup at the same idx in the same cycle: lookup sees the old entry (no bypass).
//  - redirect_i and upd_valid_i in the same cycle are both applied; they are independent.
//  - Stall (ready_i=0, no redirect): pc_o, pred_taken_o and pred_target_o remain stable.
// CONFIGURATION
//  PC_PREDICT_STATS_EN defined adds these outputs:
//   - stat_pred_o [31:0]: counts accepted fetches with pred_taken_o=1.
//   - stat_redir_o [31:0]: counts redirect_i cycles.
//   - Both reset to 0 and saturate at 32'hFFFF_FFFF.
//  PC_PREDICT_STATS_EN undefined: the ports and counters are absent; predictor behaviour is identical.
// STRUCTURE
//  pc_predict_pkg contains:
//   - btb_entry_t {valid, tag, target, ctr[1:0]}
//   - CTR_SNT=0, CTR_WNT=1, CTR_WT=2, CTR_ST=3
//   - functions btb_idx()/btb_tag() parametrised on IDX_W
//   - ctr_next(ctr,taken) saturating update
//  Sub-module btb_array: storage, async read port, one sync write port, async clear on rst_n.
//  Top level: PC register, next-PC mux, update/allocate logic, optional stats.
// TESTING (BTB_DEPTH=16, RESET_PC=0x8000_0000)
//  1. rst_n low: pc_o=0x8000_0000, pc_valid_o=0. Release with ready_i=1: pc_o steps 0x8000_0000, 0x8000_0004, 0x8000_0008.
//  2. ready_i=0 for 3 cycles at pc_o=0x8000_0008: pc_o holds; next accept gives 0x8000_000C.
//  3. redirect_i=1, redirect_pc_i=0x8000_0100 with ready_i=0: next cycle pc_o=0x8000_0100.
//  4. Allocate: upd pc=0x8000_0010, taken, target=0x8000_0040. Fetch 0x8000_0010: pred_taken_o=1, next pc_o=0x8000_0040.
//  5. Two not-taken updates at 0x8000_0010 (ctr 2->1->0). Fetch 0x8000_0010: pred_taken_o=0, next pc_o=0x8000_0014.
//     A third not-taken update leaves ctr at 0.
//  6. Alias: taken update at 0x8000_0050 (idx 4) replaces the entry. Fetch 0x8000_0010 misses; fetch 0x8000_0050 hits.
//     With PC_PREDICT_STATS_EN: stat_redir_o=1 after scenario 3.

Source files
------------

// File: rtl/pc_predict_pkg.sv
// Shared BTB types, counter encodings and index/tag/counter helpers for pc_predict_unit.
// Entry fields are sized for PCs up to BTB_FIELD_W bits; narrower PCs are zero-extended.
package pc_predict_pkg;

  localparam int BTB_FIELD_W = 32;

  localparam logic [1:0] CTR_SNT = 2'd0;
  localparam logic [1:0] CTR_WNT = 2'd1;
  localparam logic [1:0] CTR_WT  = 2'd2;
  localparam logic [1:0] CTR_ST  = 2'd3;

  typedef struct packed {
    logic                   valid;
    logic [BTB_FIELD_W-1:0] tag;
    logic [BTB_FIELD_W-1:0] target;
    logic [1:0]             ctr;
  } btb_entry_t;

  function automatic logic [BTB_FIELD_W-1:0] btb_idx(input logic [BTB_FIELD_W-1:0] pc,
                                                     input int unsigned idx_w);
    logic [BTB_FIELD_W-1:0] mask;
    mask = (BTB_FIELD_W'(1) << idx_w) - BTB_FIELD_W'(1);
    return (pc >> 2) & mask;
  endfunction

  function automatic logic [BTB_FIELD_W-1:0] btb_tag(input logic [BTB_FIELD_W-1:0] pc,
                                                     input int unsigned idx_w);
    return pc >> (idx_w + 2);
  endfunction

  // Saturating 2-bit counter: taken moves toward CTR_ST, not-taken toward CTR_SNT.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    if (taken) nxt = (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    else       nxt = (ctr == CTR_SNT || ctr == CTR_WNT) ? CTR_SNT : ctr - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/pc_predict_unit_btb_array.sv
// Direct-mapped BTB storage: two async read ports (lookup, update) and one sync write port.
// Written at the clock edge when wr_en is high; whole array cleared by async reset.
module pc_predict_unit_btb_array
  import pc_predict_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] lk_idx,
  output btb_entry_t       lk_entry,
  input  logic [IDX_W-1:0] up_idx,
  output btb_entry_t       up_entry,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  btb_entry_t       wr_entry
);

  btb_entry_t mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_entry;
    end
  end

  assign lk_entry = mem[lk_idx];
  assign up_entry = mem[up_idx];

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch-PC generator with BTB prediction; next PC registered, redirect wins, stall holds the PC.
// Optional PC_PREDICT_STATS_EN adds saturating prediction/redirect counters.
module pc_predict_unit
  import pc_predict_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              BTB_DEPTH = 16,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(32'h8000_0000)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] pc_o,
  output logic            pc_valid_o,
  input  logic            ready_i,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic [XLEN-1:0] upd_target_i,
`ifdef PC_PREDICT_STATS_EN
  input  logic            upd_taken_i,
  output logic [31:0]     stat_pred_o,
  output logic [31:0]     stat_redir_o
`else
  input  logic            upd_taken_i
`endif
);

  localparam int unsigned IDX_W = $clog2(BTB_DEPTH);

  logic [XLEN-1:0]        pc_q;
  logic                   valid_q;
  logic                   fire;
  logic [IDX_W-1:0]       lk_idx, up_idx;
  logic [BTB_FIELD_W-1:0] lk_tag, up_tag;
  btb_entry_t             lk_e, up_e, wr_e;
  logic                   wr_en;
  logic                   up_hit;

  assign lk_idx = IDX_W'(btb_idx(BTB_FIELD_W'(pc_q), IDX_W));
  assign lk_tag = btb_tag(BTB_FIELD_W'(pc_q), IDX_W);
  assign up_idx = IDX_W'(btb_idx(BTB_FIELD_W'(upd_pc_i), IDX_W));
  assign up_tag = btb_tag(BTB_FIELD_W'(upd_pc_i), IDX_W);

  pc_predict_unit_btb_array #(.DEPTH(BTB_DEPTH), .IDX_W(IDX_W)) u_btb (
    .clk      (clk),
    .rst_n    (rst_n),
    .lk_idx   (lk_idx),
    .lk_entry (lk_e),
    .up_idx   (up_idx),
    .up_entry (up_e),
    .wr_en    (wr_en),
    .wr_idx   (up_idx),
    .wr_entry (wr_e)
  );

  assign pc_o          = pc_q;
  assign pc_valid_o    = valid_q;
  assign pred_taken_o  = lk_e.valid && (lk_e.tag == lk_tag) && lk_e.ctr[1];
  assign pred_target_o = pred_taken_o ? XLEN'(lk_e.target) : '0;
  assign fire          = valid_q && ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b1;
      if (redirect_i)                pc_q <= redirect_pc_i;
      else if (fire && pred_taken_o) pc_q <= pred_target_o;
      else if (fire)                 pc_q <= pc_q + XLEN'(4);
    end
  end

  // Read-modify-write of the entry addressed by the resolved instruction.
  assign up_hit = up_e.valid && (up_e.tag == up_tag);

  always_comb begin
    wr_en = 1'b0;
    wr_e  = up_e;
    if (upd_valid_i) begin
      if (up_hit) begin
        wr_en    = 1'b1;
        wr_e.ctr = ctr_next(up_e.ctr, upd_taken_i);
        if (upd_taken_i) wr_e.target = BTB_FIELD_W'(upd_target_i);
      end else if (upd_taken_i) begin
        wr_en       = 1'b1;
        wr_e.valid  = 1'b1;
        wr_e.tag    = up_tag;
        wr_e.target = BTB_FIELD_W'(upd_target_i);
        wr_e.ctr    = CTR_WT;
      end
    end
  end

`ifdef PC_PREDICT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pred_o  <= '0;
      stat_redir_o <= '0;
    end else begin
      if (fire && pred_taken_o && stat_pred_o != 32'hFFFF_FFFF) stat_pred_o <= stat_pred_o + 32'd1;
      if (redirect_i && stat_redir_o != 32'hFFFF_FFFF) stat_redir_o <= stat_redir_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_predict_unit.sv
// Directed bench for pc_predict_unit: expected fetch outputs are queued with each step and
// compared after the following clock edge.
module tb_pc_predict_unit;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_o;
  logic        pc_valid_o;
  logic        ready_i;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic [31:0] upd_target_i;
  logic        upd_taken_i;
`ifdef PC_PREDICT_STATS_EN
  logic [31:0] stat_pred_o;
  logic [31:0] stat_redir_o;
`endif

  pc_predict_unit #(.XLEN(32), .BTB_DEPTH(16), .RESET_PC(32'h8000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_o          (pc_o),
    .pc_valid_o    (pc_valid_o),
    .ready_i       (ready_i),
    .pred_taken_o  (pred_taken_o),
    .pred_target_o (pred_target_o),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .upd_valid_i   (upd_valid_i),
    .upd_pc_i      (upd_pc_i),
    .upd_target_i  (upd_target_i),
`ifdef PC_PREDICT_STATS_EN
    .upd_taken_i   (upd_taken_i),
    .stat_pred_o   (stat_pred_o),
    .stat_redir_o  (stat_redir_o)
`else
    .upd_taken_i   (upd_taken_i)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        vld;
    logic        pt;
    logic [31:0] tgt;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic vld, input logic pt, input logic [31:0] tgt);
    exp_t e;
    e.pc = pc; e.vld = vld; e.pt = pt; e.tgt = tgt;
    sb.push_back(e);
  endtask

  task automatic check_sb(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      failed++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_pc"},  pc_o,                  e.pc);
      chk({tag, "_vld"}, {31'd0, pc_valid_o},   {31'd0, e.vld});
      chk({tag, "_pt"},  {31'd0, pred_taken_o}, {31'd0, e.pt});
      chk({tag, "_tgt"}, pred_target_o,         e.tgt);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle resolved update, fetch stalled.
  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    upd_valid_i = 1'b1; upd_pc_i = pc; upd_target_i = tgt; upd_taken_i = tk;
    step();
    upd_valid_i = 1'b0;
  endtask

  // Redirect to pc and check what the BTB predicts there.
  task automatic goto_chk(input logic [31:0] pc, input logic pt, input logic [31:0] tgt, input string tag);
    redirect_i = 1'b1; redirect_pc_i = pc;
    push(pc, 1'b1, pt, tgt);
    step();
    redirect_i = 1'b0;
    check_sb(tag);
  endtask

  initial begin
    rst_n = 1'b0; ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    upd_valid_i = 1'b0; upd_pc_i = '0; upd_target_i = '0; upd_taken_i = 1'b0;

    #12;
    push(RST_PC, 1'b0, 1'b0, 32'h0);
    check_sb("reset");

    // Release and sequential fetch
    @(posedge clk); #1;
    ready_i = 1'b1; rst_n = 1'b1;
    push(RST_PC, 1'b1, 1'b0, 32'h0);              step(); check_sb("rel0");
    push(32'h8000_0004, 1'b1, 1'b0, 32'h0);       step(); check_sb("seq4");
    push(32'h8000_0008, 1'b1, 1'b0, 32'h0);       step(); check_sb("seq8");

    // Stall
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(32'h8000_0008, 1'b1, 1'b0, 32'h0);     step(); check_sb("stall");
    end
    ready_i = 1'b1;
    push(32'h8000_000C, 1'b1, 1'b0, 32'h0);       step(); check_sb("after_stall");

    // Redirect with ready low
    ready_i = 1'b0;
    goto_chk(32'h8000_0100, 1'b0, 32'h0, "redirect");

    // Allocate and predict
    upd(32'h8000_0010, 32'h8000_0040, 1'b1);
    goto_chk(32'h8000_0010, 1'b1, 32'h8000_0040, "alloc_hit");
    ready_i = 1'b1;
    push(32'h8000_0040, 1'b1, 1'b0, 32'h0);       step(); check_sb("follow_pred");
    ready_i = 1'b0;

    // Decay to strongly not-taken
    upd(32'h8000_0010, 32'h0, 1'b0);
    upd(32'h8000_0010, 32'h0, 1'b0);
    goto_chk(32'h8000_0010, 1'b0, 32'h0, "decayed");
    ready_i = 1'b1;
    push(32'h8000_0014, 1'b1, 1'b0, 32'h0);       step(); check_sb("no_pred_seq");
    ready_i = 1'b0;

    // Saturation at 0, then retrain with target rewrite
    upd(32'h8000_0010, 32'h0, 1'b0);
    upd(32'h8000_0010, 32'h8000_0080, 1'b1);
    goto_chk(32'h8000_0010, 1'b0, 32'h0, "sat_low");
    upd(32'h8000_0010, 32'h8000_0090, 1'b1);
    goto_chk(32'h8000_0010, 1'b1, 32'h8000_0090, "retrained");

    // Alias replaces idx 4
    upd(32'h8000_0050, 32'h8000_00A0, 1'b1);
    goto_chk(32'h8000_0010, 1'b0, 32'h0, "alias_miss");
    ready_i = 1'b1;
    push(32'h8000_0014, 1'b1, 1'b0, 32'h0);       step(); check_sb("alias_seq");
    ready_i = 1'b0;
    goto_chk(32'h8000_0050, 1'b1, 32'h8000_00A0, "alias_hit");

    // Update at the looked-up idx: lookup sees old entry this cycle
    upd_valid_i = 1'b1; upd_pc_i = 32'h8000_0050; upd_target_i = '0; upd_taken_i = 1'b0;
    #1;
    push(32'h8000_0050, 1'b1, 1'b1, 32'h8000_00A0);
    check_sb("no_bypass");
    step();
    upd_valid_i = 1'b0;
    push(32'h8000_0050, 1'b1, 1'b0, 32'h0);
    check_sb("after_upd");
    ready_i = 1'b1;
    push(32'h8000_0054, 1'b1, 1'b0, 32'h0);       step(); check_sb("seq54");

    // Redirect beats an accepted fetch; concurrent update still applies
    redirect_i = 1'b1; redirect_pc_i = 32'h8000_0200;
    upd_valid_i = 1'b1; upd_pc_i = 32'h8000_0050; upd_target_i = 32'h8000_00B0; upd_taken_i = 1'b1;
    push(32'h8000_0200, 1'b1, 1'b0, 32'h0);       step(); check_sb("redir_drop");
    redirect_i = 1'b0; upd_valid_i = 1'b0; ready_i = 1'b0;
    goto_chk(32'h8000_0050, 1'b1, 32'h8000_00B0, "redir_upd");

    // Wrap and unaligned pass-through
    goto_chk(32'hFFFF_FFFC, 1'b0, 32'h0, "wrap_at");
    ready_i = 1'b1;
    push(32'h0000_0000, 1'b1, 1'b0, 32'h0);       step(); check_sb("wrap");
    ready_i = 1'b0;
    goto_chk(32'h8000_0003, 1'b0, 32'h0, "unal_at");
    ready_i = 1'b1;
    push(32'h8000_0007, 1'b1, 1'b0, 32'h0);       step(); check_sb("unal");
    ready_i = 1'b0;

    // Mid-operation reset with an update pending
    upd_valid_i = 1'b1; upd_pc_i = 32'h8000_0060; upd_target_i = 32'h8000_00C0; upd_taken_i = 1'b1;
    rst_n = 1'b0;
    #1;
    push(RST_PC, 1'b0, 1'b0, 32'h0);
    check_sb("mid_reset");
    step();
    upd_valid_i = 1'b0; rst_n = 1'b1;
    push(RST_PC, 1'b1, 1'b0, 32'h0);              step(); check_sb("rerelease");
    goto_chk(32'h8000_0050, 1'b0, 32'h0, "cleared");
    goto_chk(32'h8000_0060, 1'b0, 32'h0, "aborted_upd");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
